// File: rtl/obstacle_collision_tracker_if.sv
// Signal bundle between the motion blocks / colour mapper and the per-frame game-state engine.
// The slave side is the tracker; the master side drives ball/obstacle geometry and the button.
interface obstacle_collision_tracker_if #(
  parameter int N_OBS      = 4,
  parameter int COORD_W    = 10,
  parameter int NUM_LEVELS = 4
);
  localparam int LVL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;

  logic [COORD_W-1:0]       BallX;
  logic [COORD_W-1:0]       BallY;
  logic [COORD_W-1:0]       Ball_size;
  logic [N_OBS*COORD_W-1:0] ObsX_flat;
  logic [N_OBS*COORD_W-1:0] ObsY_flat;
  logic [N_OBS*COORD_W-1:0] ObsSize_flat;
  logic [N_OBS-1:0]         obs_enable;
  logic                     continue_btn;

  logic [N_OBS-1:0]         collision;
  logic                     collision_any;
  logic                     reset_player;
  logic                     finish_line_reached;
  logic [LVL_W-1:0]         current_level;
  logic [2:0]               lives;
  logic                     invuln_active;
  logic [1:0]               game_state;

  modport master (
    output BallX, BallY, Ball_size, ObsX_flat, ObsY_flat, ObsSize_flat, obs_enable, continue_btn,
    input  collision, collision_any, reset_player, finish_line_reached, current_level, lives,
           invuln_active, game_state
  );

  modport slave (
    input  BallX, BallY, Ball_size, ObsX_flat, ObsY_flat, ObsSize_flat, obs_enable, continue_btn,
    output collision, collision_any, reset_player, finish_line_reached, current_level, lives,
           invuln_active, game_state
  );
endinterface

// File: rtl/obstacle_collision_tracker.sv
// Per-frame game-state engine: ball/obstacle overlap, lives, invulnerability window,
// finish-line detection, level advance and game over.
module obstacle_collision_tracker #(
  parameter int N_OBS         = 4,
  parameter int COORD_W       = 10,
  parameter int FINISH_X      = 580,
  parameter int LIVES_INIT    = 3,
  parameter int INVULN_FRAMES = 30,
  parameter int NUM_LEVELS    = 4
) (
  input logic                       frame_clk,
  input logic                       reset,
  obstacle_collision_tracker_if.slave bus
);
  localparam int EXT_W = COORD_W + 2;
  localparam int LVL_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
  localparam int CNT_W = $clog2(INVULN_FRAMES + 1);

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    HIT        = 2'd1,
    LEVEL_DONE = 2'd2,
    GAME_OVER  = 2'd3
  } state_t;

  state_t             state, state_next;
  logic [N_OBS-1:0]   overlap, hit_vec, collision_q;
  logic [2:0]         lives_q, lives_next;
  logic [LVL_W-1:0]   level_q, level_next;
  logic [CNT_W-1:0]   cnt_q, cnt_next;
  logic               rp_q, rp_next, prev_btn;
  logic               cont_rise, finish, any_hit;

  // Add-only form of |a-b| < sa+sb, widened so the sums cannot wrap.
  function automatic logic box_overlap(
    input logic [COORD_W-1:0] bx, by, bs, ox, oy, os
  );
    logic [EXT_W-1:0] ebx, eby, ebs, eox, eoy, eos;
    ebx = EXT_W'(bx); eby = EXT_W'(by); ebs = EXT_W'(bs);
    eox = EXT_W'(ox); eoy = EXT_W'(oy); eos = EXT_W'(os);
    return (ebx + ebs + eos > eox) && (eox + eos + ebs > ebx) &&
           (eby + ebs + eos > eoy) && (eoy + eos + ebs > eby);
  endfunction

  always_comb begin
    overlap = '0;
    for (int i = 0; i < N_OBS; i++) begin
      overlap[i] = box_overlap(bus.BallX, bus.BallY, bus.Ball_size,
                               bus.ObsX_flat[i*COORD_W +: COORD_W],
                               bus.ObsY_flat[i*COORD_W +: COORD_W],
                               bus.ObsSize_flat[i*COORD_W +: COORD_W]);
    end
  end

  assign hit_vec   = bus.obs_enable & overlap;
  assign any_hit   = |hit_vec;
  assign finish    = (EXT_W'(bus.BallX) >= EXT_W'(FINISH_X));
  assign cont_rise = bus.continue_btn & ~prev_btn;

  always_ff @(posedge frame_clk) begin
    if (reset) begin
      state       <= PLAY;
      lives_q     <= 3'(LIVES_INIT);
      level_q     <= '0;
      cnt_q       <= '0;
      rp_q        <= 1'b0;
      prev_btn    <= 1'b0;
      collision_q <= '0;
    end else begin
      state       <= state_next;
      lives_q     <= lives_next;
      level_q     <= level_next;
      cnt_q       <= cnt_next;
      rp_q        <= rp_next;
      prev_btn    <= bus.continue_btn;
      collision_q <= hit_vec;
    end
  end

  always_comb begin
    state_next = state;
    lives_next = lives_q;
    level_next = level_q;
    cnt_next   = cnt_q;
    rp_next    = 1'b0;
    unique case (state)
      PLAY: begin
        // Reaching the finish wins over a hit in the same frame.
        if (finish) begin
          state_next = LEVEL_DONE;
        end else if (any_hit && lives_q != 3'd0) begin
          lives_next = lives_q - 3'd1;
          if (lives_q == 3'd1) begin
            state_next = GAME_OVER;
          end else begin
            state_next = HIT;
            cnt_next   = CNT_W'(INVULN_FRAMES);
            rp_next    = 1'b1;
          end
        end
      end
      HIT: begin
        if (finish) begin
          state_next = LEVEL_DONE;
          cnt_next   = '0;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_next = PLAY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_q - CNT_W'(1);
        end
      end
      LEVEL_DONE: begin
        if (cont_rise) begin
          state_next = PLAY;
          rp_next    = 1'b1;
          level_next = (level_q == LVL_W'(NUM_LEVELS - 1)) ? '0 : level_q + LVL_W'(1);
        end
      end
      GAME_OVER: begin
        lives_next = 3'd0;
        if (cont_rise) begin
          state_next = PLAY;
          rp_next    = 1'b1;
          level_next = '0;
          lives_next = 3'(LIVES_INIT);
        end
      end
      default: state_next = PLAY;
    endcase
  end

  assign bus.collision           = collision_q;
  assign bus.collision_any       = |collision_q;
  assign bus.reset_player        = rp_q;
  assign bus.finish_line_reached = (state == LEVEL_DONE);
  assign bus.invuln_active       = (state == HIT);
  assign bus.current_level       = level_q;
  assign bus.lives               = lives_q;
  assign bus.game_state          = state;
endmodule
